uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that lets NUM_REQ byte-stream requesters share one UART transmitter.
- Forwards each byte by pulsing the transmitter's start strobe.
- Waits for the transmitter's done tick before sending the next byte.
- Holds a grant for a whole packet, delimited by a last flag, so packets from different requesters never interleave on the serial line.
- Sits between the system's message sources and the UART transmitter, alongside the baud-tick generator.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- IDW, 2, width of the requester index; must satisfy 2**IDW >= NUM_REQ.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NUM_REQ  marks the final byte of a packet; qualified by req_valid.
- req_ready  output  NUM_REQ  byte accepted; a transfer occurs when valid and ready are both high.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- grant_id  output  IDW  binary index of the owner; 0 when idle.
- busy  output  1  high whenever state is not IDLE.
- tx_start  output  1  one-cycle start strobe to the UART transmitter.
- tx_din  output  8  byte to the transmitter; valid only while tx_start is high, 0 otherwise.
- tx_done_tick  input  1  one-cycle pulse from the transmitter at the end of the stop bit.

Behaviour:
- Reset (reset_n low at a clock edge): state IDLE; grant=0, grant_id=0, rr pointer=0, last flag=0. Combinationally, busy=0, tx_start=0, tx_din=0, req_ready=0.
- Reset mid-packet aborts the packet with no further strobes. Any byte already in flight in the transmitter is not tracked; a tx_done_tick arriving after reset while in IDLE is ignored.
- State IDLE:
  - If any req_valid is high, choose the first set bit searching upward from rr pointer with wrap (ptr, ptr+1, …, NUM_REQ-1, 0, …).
  - Register grant and grant_id for the winner; set rr pointer to (winner+1) mod NUM_REQ; go to LOAD.
  - With no valid requester, stay in IDLE.
- State LOAD: output decode is combinational from state and the inputs.
  - If req_valid[grant_id]=1: tx_start=1, tx_din=req_data of owner, req_ready[grant_id]=1. Register last flag from req_last[grant_id]; go to WAIT_DONE.
  - If req_valid[grant_id]=0: stall in LOAD with the grant held. Other requesters are not served.
- State WAIT_DONE: on tx_done_tick, go to IDLE if last flag=1 (grant cleared to 0 on that edge), otherwise go to LOAD. With no tick, wait.
- tx_done_tick in IDLE or LOAD is ignored.
- Latency:
  - Valid in IDLE at cycle 0 gives grant at cycle 1 and tx_start at cycle 1.
  - Between bytes of one packet: tx_start occurs 1 cycle after tx_done_tick.
  - Next packet: tx_start occurs 2 cycles after the final tx_done_tick.
- At most one req_ready bit is ever high. tx_start is never high outside LOAD (or HDR, see below).
- Non-granted requesters' valid, data and last are ignored. A requester dropping valid mid-packet stalls the arbiter by design.
- Simultaneous requests in IDLE are resolved purely by the rr pointer. The pointer advances only on grant.
- busy is high in LOAD, WAIT_DONE, HDR and HDR_WAIT.

Optional Feature:
- Macro: UART_TX_ARB_HDR_EN.
- Defined: after IDLE grants, enter HDR instead of LOAD.
  - HDR: tx_start=1, tx_din={4'hA, 4-bit zero-extended grant_id}, req_ready stays 0; go to HDR_WAIT.
  - HDR_WAIT: on tx_done_tick, go to LOAD.
  - Each packet on the line is prefixed with its source ID byte; first-payload latency grows by one UART frame plus 1 cycle.
- Undefined: HDR and HDR_WAIT are absent; behaviour exactly as above.

Test Plan:
- Reset, then single packet: req_valid[1]=1, data 8'h55 with last=1. Expect grant=4'b0010 and tx_start with tx_din=8'h55 one cycle after valid. After the emulated tx_done_tick, grant returns to 0 within 1 cycle and the pointer becomes 2.
- Three-byte packet from req 0 (8'h01, 8'h02, 8'h03 with last on 8'h03): expect three tx_start pulses, each exactly 1 cycle after the preceding done tick, and req_ready[0] high only in those cycles.
- All four requesters valid with 1-byte packets from reset: expect the service order 0,1,2,3; then reassert req 0 and req 3 → 0 is served before 3, because the pointer wrapped to 0.
- Starvation check: req 2 holds valid continuously while req 1 also requests → alternation 1,2,1,2…; req 2 is never granted twice in a row while req 1 waits.
- Stall and reset: req 3 sends a non-last byte then drops valid → arbiter stays in LOAD with grant=4'b1000 and no tx_start. Pulse reset_n low for one cycle → grant=0, busy=0. A stray tx_done_tick afterwards produces no tx_start.
- With UART_TX_ARB_HDR_EN, req 2 sends packet 8'hC3 with last=1 → first tx_start carries 8'hA2 with req_ready=0; after its done tick, the second tx_start carries 8'hC3 with req_ready[2]=1.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the UART transmit arbiter.
// master = arbiter side, slave = requesters / transmitter / bench.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   grant;
   logic [IDW-1:0]       grant_id;
   logic                 busy;
   logic                 tx_start;
   logic [7:0]           tx_din;
   logic                 tx_done_tick;

   modport master (
      input  req_valid, req_data, req_last, tx_done_tick,
      output req_ready, grant, grant_id, busy, tx_start, tx_din
   );
   modport slave (
      output req_valid, req_data, req_last, tx_done_tick,
      input  req_ready, grant, grant_id, busy, tx_start, tx_din
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter feeding NUM_REQ byte streams into one UART transmitter.
// Define UART_TX_ARB_HDR_EN to prefix every packet with a {4'hA, id} source byte.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   uart_tx_arbiter_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      WAIT_DONE = 3'd2
`ifdef UART_TX_ARB_HDR_EN
      ,
      HDR       = 3'd3,
      HDR_WAIT  = 3'd4
`endif
   } state_t;

   state_t             state, state_n;
   logic [NUM_REQ-1:0] grant_q, grant_n;
   logic [IDW-1:0]     gid_q, gid_n, ptr_q, ptr_n, win_id;
   logic               last_q, last_n, win_found;
   logic               own_valid, own_last;
   logic [7:0]         own_data;
   logic               tx_start;
   logic [7:0]         tx_din;
   logic [NUM_REQ-1:0] req_ready;

   // Rotating priority: scan ptr..NUM_REQ-1 first, then 0..ptr-1.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && i >= int'(ptr_q) && bus.req_valid[i]) begin
            win_found = 1'b1;
            win_id    = IDW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_found && i < int'(ptr_q) && bus.req_valid[i]) begin
            win_found = 1'b1;
            win_id    = IDW'(i);
         end
      end
   end

   // Owner's stream selected through the one-hot grant.
   always_comb begin
      own_valid = |(bus.req_valid & grant_q);
      own_last  = |(bus.req_last & grant_q);
      own_data  = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant_q[i]) own_data = own_data | bus.req_data[8*i +: 8];
   end

   always_comb begin
      state_n   = state;
      grant_n   = grant_q;
      gid_n     = gid_q;
      ptr_n     = ptr_q;
      last_n    = last_q;
      tx_start  = 1'b0;
      tx_din    = '0;
      req_ready = '0;
      case (state)
         IDLE: if (win_found) begin
            grant_n = NUM_REQ'(1) << win_id;
            gid_n   = win_id;
            ptr_n   = (win_id == IDW'(NUM_REQ-1)) ? '0 : win_id + IDW'(1);
`ifdef UART_TX_ARB_HDR_EN
            state_n = HDR;
`else
            state_n = LOAD;
`endif
         end
         LOAD: if (own_valid) begin
            tx_start  = 1'b1;
            tx_din    = own_data;
            req_ready = grant_q;
            last_n    = own_last;
            state_n   = WAIT_DONE;
         end
         WAIT_DONE: if (bus.tx_done_tick) begin
            if (last_q) begin
               state_n = IDLE;
               grant_n = '0;
               gid_n   = '0;
            end else begin
               state_n = LOAD;
            end
         end
`ifdef UART_TX_ARB_HDR_EN
         HDR: begin
            tx_start = 1'b1;
            tx_din   = {4'hA, 4'(gid_q)};
            state_n  = HDR_WAIT;
         end
         HDR_WAIT: if (bus.tx_done_tick) state_n = LOAD;
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         grant_q <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state   <= state_n;
         grant_q <= grant_n;
         gid_q   <= gid_n;
         ptr_q   <= ptr_n;
         last_q  <= last_n;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.grant_id  = gid_q;
   assign bus.busy      = (state != IDLE);
   assign bus.tx_start  = tx_start;
   assign bus.tx_din    = tx_din;
   assign bus.req_ready = req_ready;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-fed requesters, emulated UART, per-cycle model compare
// plus hand-computed expectations on service order and latency.
module tb_uart_tx_arbiter;
   localparam int N     = 4;
   localparam int IDW   = 2;
   localparam int FRAME = 3;
`ifdef UART_TX_ARB_HDR_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif
   localparam int P_SEND = 0, P_WAIT = 1, P_HDR = 2, P_HDRW = 3;

   logic clk = 1'b0;
   logic reset_n;
   logic auto_tick = 1'b0, man_tick = 1'b0;
   bit   chk_en = 1'b0;
   int   tests = 0, fails = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_arbiter_if #(.NUM_REQ(N), .IDW(IDW)) bus ();
   uart_tx_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   assign bus.tx_done_tick = auto_tick | man_tick;

   // Requester byte queues: {last, data}
   logic [8:0] rq [N][$];
   int pay_id[$], pay_dat[$], pay_cyc[$], tk_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Requester driver: pop on accepted handshake, present queue heads
   initial begin
      logic [N-1:0] acc, v, l;
      logic [8*N-1:0] d;
      bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
      forever begin
         @(negedge clk);
         acc = reset_n ? (bus.req_valid & bus.req_ready) : '0;
         @(posedge clk); #1;
         v = '0; l = '0; d = '0;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
               v[i] = 1'b1;
               l[i] = rq[i][0][8];
               d[8*i +: 8] = rq[i][0][7:0];
            end
         end
         bus.req_valid = v; bus.req_last = l; bus.req_data = d;
      end
   end

   // UART emulation: done tick FRAME cycles after each start strobe
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            repeat (FRAME) @(posedge clk);
            #1 auto_tick = 1'b1;
            @(posedge clk);
            #1 auto_tick = 1'b0;
         end
      end
   end

   // Reference model: current owner (-1 = nobody), what it waits for, rotating pointer
   int m_owner = -1, m_phase = 0, m_ptr = 0, mw;
   bit m_last = 1'b0;
   always @(posedge clk) begin
      if (!reset_n) begin
         m_owner <= -1; m_ptr <= 0; m_phase <= P_SEND; m_last <= 1'b0;
      end else if (m_owner < 0) begin
         mw = -1;
         for (int k = 0; k < N; k++)
            if (mw < 0 && bus.req_valid[(m_ptr + k) % N]) mw = (m_ptr + k) % N;
         if (mw >= 0) begin
            m_owner <= mw;
            m_ptr   <= (mw + 1) % N;
            m_phase <= HDR ? P_HDR : P_SEND;
         end
      end else begin
         case (m_phase)
            P_SEND: if (bus.req_valid[m_owner]) begin
               m_last  <= bus.req_last[m_owner];
               m_phase <= P_WAIT;
            end
            P_WAIT: if (bus.tx_done_tick) begin
               if (m_last) m_owner <= -1;
               else m_phase <= P_SEND;
            end
            P_HDR:  m_phase <= P_HDRW;
            default: if (bus.tx_done_tick) m_phase <= P_SEND;
         endcase
      end
   end

   // Per-cycle compare and transaction log
   always @(negedge clk) begin
      logic [N-1:0] eg, er;
      logic [IDW-1:0] eid;
      logic es, eb, fire, hs;
      logic [7:0] ed;
      if (chk_en) begin
         eb   = (m_owner >= 0);
         eg   = eb ? N'(1 << m_owner) : '0;
         eid  = eb ? IDW'(m_owner) : '0;
         fire = eb && m_phase == P_SEND && bus.req_valid[m_owner] === 1'b1;
         hs   = eb && m_phase == P_HDR;
         es   = fire | hs;
         ed   = fire ? bus.req_data[8*m_owner +: 8] : hs ? {4'hA, 4'(m_owner)} : 8'h00;
         er   = fire ? eg : '0;
         tests++;
         if (bus.grant !== eg || bus.grant_id !== eid || bus.busy !== eb ||
             bus.tx_start !== es || bus.tx_din !== ed || bus.req_ready !== er) begin
            fails++;
            $display("FAIL model cyc %0d: grant %b/%b id %0d/%0d busy %b/%b start %b/%b din %h/%h ready %b/%b",
                     cyc, bus.grant, eg, bus.grant_id, eid, bus.busy, eb, bus.tx_start, es,
                     bus.tx_din, ed, bus.req_ready, er);
         end
         if (bus.tx_start === 1'b1 && |bus.req_ready) begin
            pay_id.push_back(int'(bus.grant_id));
            pay_dat.push_back(int'(bus.tx_din));
            pay_cyc.push_back(cyc);
         end
         if (bus.tx_done_tick === 1'b1) tk_cyc.push_back(cyc);
      end
   end

   function automatic int prev_tick(input int c);
      int r = -1000;
      foreach (tk_cyc[i]) if (tk_cyc[i] < c) r = tk_cyc[i];
      return r;
   endfunction

   task automatic wait_payloads(input int n, input string name);
      int b = 0;
      while (pay_id.size() < n) begin
         @(posedge clk); #2;
         if (++b > 500) begin chk({name, "_timeout"}, pay_id.size(), n); return; end
      end
   endtask

   task automatic wait_idle(input string name);
      int b = 0;
      do begin
         @(posedge clk); #2;
         if (++b > 500) begin chk({name, "_idle_timeout"}, bus.busy, 0); return; end
      end while (bus.busy !== 1'b0);
   endtask

   task automatic wait_sig_neg(input int which, input string name);
      int b = 0;
      do begin
         @(negedge clk);
         if (++b > 500) begin chk({name, "_timeout"}, 0, 1); return; end
      end while (!((which == 0 && bus.req_valid[1] === 1'b1) ||
                   (which == 1 && bus.tx_done_tick === 1'b1) ||
                   (which == 2 && bus.tx_start === 1'b1)));
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2 reset_n = 1'b0;
      @(posedge clk); #2 reset_n = 1'b1;
   endtask

   initial begin
      int b, tk;
      reset_n = 1'b0;
      @(posedge clk); #2 chk_en = 1'b1;
      @(negedge clk);
      chk("rst_grant", bus.grant, 4'b0000);
      chk("rst_busy", bus.busy, 0);
      chk("rst_start", bus.tx_start, 0);
      chk("rst_ready", bus.req_ready, 4'b0000);
      @(posedge clk); #2 reset_n = 1'b1;

      // Single-byte packet from requester 1
      rq[1].push_back({1'b1, 8'h55});
      wait_sig_neg(0, "t1_valid");
      chk("t1_grant_c0", bus.grant, 4'b0000);
      @(negedge clk);
      chk("t1_grant_c1", bus.grant, 4'b0010);
      chk("t1_start_c1", bus.tx_start, 1);
      chk("t1_din_c1", bus.tx_din, HDR ? 8'hA1 : 8'h55);
      chk("t1_ready_c1", bus.req_ready, HDR ? 4'b0000 : 4'b0010);
      tk = 0;
      while (tk < (HDR ? 2 : 1)) begin wait_sig_neg(1, "t1_tick"); tk++; end
      @(negedge clk);
      chk("t1_grant_after", bus.grant, 4'b0000);
      chk("t1_busy_after", bus.busy, 0);

      // Three-byte packet from requester 0
      @(posedge clk); #2 b = pay_id.size();
      rq[0].push_back({1'b0, 8'h01});
      rq[0].push_back({1'b0, 8'h02});
      rq[0].push_back({1'b1, 8'h03});
      wait_payloads(b + 3, "t2");
      wait_idle("t2");
      for (int k = 0; k < 3; k++) begin
         chk("t2_data", pay_dat[b+k], k + 1);
         chk("t2_id", pay_id[b+k], 0);
      end
      for (int k = 1; k < 3; k++)
         chk("t2_gap", pay_cyc[b+k] - prev_tick(pay_cyc[b+k]), 1);

      // All four from reset, then 0 and 3 after pointer wrap
      pulse_reset();
      @(posedge clk); #2 b = pay_id.size();
      for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
      wait_payloads(b + 4, "t3a");
      wait_idle("t3a");
      rq[0].push_back({1'b1, 8'h20});
      rq[3].push_back({1'b1, 8'h23});
      wait_payloads(b + 6, "t3b");
      wait_idle("t3b");
      begin
         int exp_ord [6] = '{0, 1, 2, 3, 0, 3};
         for (int k = 0; k < 6; k++) chk("t3_order", pay_id[b+k], exp_ord[k]);
      end
      chk("t3_next_pkt_gap", pay_cyc[b+1] - prev_tick(pay_cyc[b+1]), HDR ? 1 : 2);

      // Requester 2 always valid while requester 1 also asks
      @(posedge clk); #2 b = pay_id.size();
      for (int k = 0; k < 4; k++) rq[2].push_back({1'b1, 8'(8'h20 + k)});
      for (int k = 0; k < 3; k++) rq[1].push_back({1'b1, 8'(8'h30 + k)});
      wait_payloads(b + 7, "t4");
      wait_idle("t4");
      begin
         int exp_ord [7] = '{1, 2, 1, 2, 1, 2, 2};
         for (int k = 0; k < 7; k++) chk("t4_order", pay_id[b+k], exp_ord[k]);
      end
      chk("t4_first_data", pay_dat[b], 8'h30);

      // Stall in LOAD, abort by reset, stray done tick
      @(posedge clk); #2 b = pay_id.size();
      rq[3].push_back({1'b0, 8'hAB});
      wait_payloads(b + 1, "t5");
      repeat (FRAME + 4) @(posedge clk);
      @(negedge clk);
      chk("t5_stall_grant", bus.grant, 4'b1000);
      chk("t5_stall_start", bus.tx_start, 0);
      chk("t5_stall_busy", bus.busy, 1);
      pulse_reset();
      @(negedge clk);
      chk("t5_rst_grant", bus.grant, 4'b0000);
      chk("t5_rst_busy", bus.busy, 0);
      @(posedge clk); #2 man_tick = 1'b1;
      @(posedge clk); #2 man_tick = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5_stray_start", bus.tx_start, 0);
         chk("t5_stray_busy", bus.busy, 0);
      end

`ifdef UART_TX_ARB_HDR_EN
      // Header byte ahead of payload
      @(posedge clk); #2 rq[2].push_back({1'b1, 8'hC3});
      wait_sig_neg(2, "t6_hdr");
      chk("t6_hdr_din", bus.tx_din, 8'hA2);
      chk("t6_hdr_ready", bus.req_ready, 4'b0000);
      wait_sig_neg(2, "t6_pay");
      chk("t6_pay_din", bus.tx_din, 8'hC3);
      chk("t6_pay_ready", bus.req_ready, 4'b0100);
      wait_idle("t6");
`endif

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
